// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines, frames 11-bit
// words and decodes scancode prefixes into a toggling key-event word.
module ps2_key_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      clk_sync;
  logic [1:0]      data_sync;
  logic            filt_clk;
  logic [FW-1:0]   fcnt;
  logic            fall;
  logic            fall_data;
  logic [3:0]      bit_cnt;
  logic [9:0]      sr;
  logic [TW-1:0]   tcnt;
  logic            ext;
  logic            rel;
  logic [2:0]      skip;

  logic [7:0]      rx_byte;
  logic            frame_ok;
  logic            is_noise;

  // Frame is good when the stop bit is high and data+parity has odd weight.
  assign rx_byte  = sr[7:0];
  assign frame_ok = sr[9] & (^sr[8:0]);

  always_comb begin
    is_noise = 1'b0;
    case (rx_byte)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_noise = 1'b1;
      default: is_noise = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // The filtered clock only follows after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      filt_clk  <= 1'b1;
      fcnt      <= '0;
      fall      <= 1'b0;
      fall_data <= 1'b1;
    end else begin
      fall      <= 1'b0;
      fall_data <= data_sync[1];
      if (clk_sync[1] == filt_clk) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        fcnt     <= '0;
        fall     <= ~clk_sync[1];
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sr      <= '0;
      tcnt    <= '0;
      ext     <= 1'b0;
      rel     <= 1'b0;
      skip    <= '0;
      ps2_key <= '0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (fall && !fall_data) begin
            state   <= RECV;
            bit_cnt <= 4'd1;
          end
        end
        RECV: begin
          if (fall) begin
            sr      <= {fall_data, sr[9:1]};
            tcnt    <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd10) state <= CHECK;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tcnt    <= '0;
            err     <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        CHECK: begin
          state   <= IDLE;
          bit_cnt <= '0;
          if (!frame_ok) begin
            err <= 1'b1;
            ext <= 1'b0;
            rel <= 1'b0;
          end else if (skip != 3'd0) begin
            // Pause/Break sequence: the last swallowed byte produces the event.
            skip <= skip - 3'd1;
            if (skip == 3'd1) ps2_key <= {~ps2_key[10], 1'b1, 1'b1, 8'h77};
          end else if (rx_byte == 8'hE1) begin
            skip <= 3'd7;
          end else if (rx_byte == 8'hE0) begin
            ext <= 1'b1;
          end else if (rx_byte == 8'hF0) begin
            rel <= 1'b1;
          end else if (ext && (rx_byte == 8'h12 || rx_byte == 8'h59)) begin
            ext <= 1'b0;
            rel <= 1'b0;
          end else if (!ext && !rel && is_noise) begin
            ext <= 1'b0;
          end else begin
            ps2_key <= {~ps2_key[10], ~rel, ext, rx_byte};
            ext     <= 1'b0;
            rel     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: frames are bit-banged on the PS/2 lines, expected key
// events go into a queue and a monitor compares every ps2_key change.
module tb_ps2_key_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 1000;
  localparam int H          = 20;

  logic        clk_sys;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        err;

  logic [10:0] exp_q[$];
  int          checks;
  int          errors;
  int          err_cnt;
  int          exp_err;
  logic        exp_tog;

  ps2_key_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .err      (err)
  );

  // clock / reset
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  task automatic check_eq(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_sys);
  endtask

  task automatic expect_event(input logic pressed, input logic ext, input logic [7:0] code);
    exp_tog = ~exp_tog;
    exp_q.push_back({exp_tog, pressed, ext, code});
  endtask

  // Drives nbits of an 11-bit frame; glitch_bit selects a high phase with a short low pulse.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits,
                            input int glitch_bit);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        wait_cycles(5);
        ps2_clk = 1'b0;
        wait_cycles(3);
        ps2_clk = 1'b1;
        wait_cycles(H - 8);
      end else begin
        wait_cycles(H);
      end
      ps2_clk = 1'b0;
      wait_cycles(H);
      ps2_clk = 1'b1;
    end
    wait_cycles(2 * H);
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11, -1);
  endtask

  // monitor: every ps2_key change pops one expected event; err must be single-cycle
  initial begin
    logic [10:0] prev;
    logic        err_prev;
    logic        rst_d;
    prev     = '0;
    err_prev = 1'b0;
    rst_d    = 1'b1;
    forever begin
      @(negedge clk_sys);
      if (reset || rst_d) begin
        prev     = ps2_key;
        err_prev = 1'b0;
      end else begin
        if (ps2_key !== prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got 0x%0h with nothing expected", ps2_key);
          end else begin
            check_eq("ps2_key_event", int'(ps2_key), int'(exp_q.pop_front()));
          end
          prev = ps2_key;
        end
        if (err && err_prev) begin
          checks++;
          errors++;
          $display("FAIL err_width: err high for more than one cycle");
        end
        if (err && !err_prev) err_cnt++;
        err_prev = err;
      end
      rst_d = reset;
    end
  end

  // stimulus
  initial begin
    checks   = 0;
    errors   = 0;
    err_cnt  = 0;
    exp_err  = 0;
    exp_tog  = 1'b0;
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(5);
    @(negedge clk_sys);
    check_eq("reset_ps2_key", int'(ps2_key), 0);
    check_eq("reset_err", int'(err), 0);
    reset = 1'b0;
    wait_cycles(20);

    // plain make code 0x1C -> 0x61C
    expect_event(1'b1, 1'b0, 8'h1C);
    send_byte(8'h1C);
    check_eq("err_after_1c", err_cnt, exp_err);

    // extended release E0 F0 6B -> 0x16B
    send_byte(8'hE0);
    send_byte(8'hF0);
    expect_event(1'b0, 1'b1, 8'h6B);
    send_byte(8'h6B);

    // F0 then bad parity clears the flag; 0x1A is a plain press
    send_byte(8'hF0);
    send_frame(8'h1C, 1'b1, 11, -1);
    exp_err++;
    check_eq("err_bad_parity", err_cnt, exp_err);
    expect_event(1'b1, 1'b0, 8'h1A);
    send_byte(8'h1A);

    // partial frame then timeout
    send_frame(8'h55, 1'b0, 5, -1);
    wait_cycles(TIMEOUT + 100);
    exp_err++;
    check_eq("err_timeout", err_cnt, exp_err);
    check_eq("state_idle_after_timeout", int'(dut.state), 0);
    expect_event(1'b1, 1'b0, 8'h29);
    send_byte(8'h29);

    // noise byte and fake shift produce no event
    send_byte(8'hAA);
    send_byte(8'hE0);
    send_byte(8'h12);

    // pause sequence -> a single 0x777-style event
    send_byte(8'hE1);
    send_byte(8'h14);
    send_byte(8'h77);
    send_byte(8'hE1);
    send_byte(8'hF0);
    send_byte(8'h14);
    send_byte(8'hF0);
    expect_event(1'b1, 1'b1, 8'h77);
    send_byte(8'h77);

    // 3-cycle low glitch inside a frame is filtered out
    expect_event(1'b1, 1'b0, 8'h5A);
    send_frame(8'h5A, 1'b0, 11, 4);
    check_eq("err_after_glitch", err_cnt, exp_err);
    check_eq("queue_drained_mid", exp_q.size(), 0);

    // reset mid-frame, then a clean frame decodes from reset state
    send_frame(8'h33, 1'b0, 5, -1);
    reset = 1'b1;
    wait_cycles(4);
    @(negedge clk_sys);
    check_eq("midframe_reset_key", int'(ps2_key), 0);
    reset = 1'b0;
    ps2_data = 1'b1;
    exp_tog = 1'b0;
    wait_cycles(10);
    expect_event(1'b1, 1'b0, 8'h1C);
    send_byte(8'h1C);

    begin
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 2000) begin
        wait_cycles(1);
        budget++;
      end
    end
    check_eq("queue_drained_end", exp_q.size(), 0);
    check_eq("err_total", err_cnt, exp_err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_rx.md
PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, meaning clk_sys cycles ps2_clk must be stable before its filtered value changes.
REQ-002 SHALL have parameter TIMEOUT, default 100000, meaning clk_sys cycles without a ps2_clk falling edge before an open frame is abandoned.
REQ-003 SHALL have port clk_sys  in  1  system clock; the only clock.
REQ-004 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port ps2_clk  in  1  raw PS/2 clock line, asynchronous.
REQ-006 SHALL have port ps2_data  in  1  raw PS/2 data line, asynchronous.
REQ-007 SHALL have port ps2_key  out  11  key event: [10] toggles once per event, [9] pressed, [8] extended, [7:0] scancode.
REQ-008 SHALL have port err  out  1  one-cycle pulse on frame error or timeout.

Function
REQ-009 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer.
REQ-010 SHALL change filtered clock only after FILTER_LEN consecutive equal synchronized samples differing from it; shorter pulses ignored.
REQ-011 SHALL sample synchronized ps2_data on each filtered-clock falling edge.
REQ-012 SHALL run frame FSM IDLE -> RECV -> CHECK -> IDLE; 11-bit frame: start 0, 8 data LSB first, odd parity, stop 1.
REQ-013 SHALL in IDLE, on falling edge with data 0, enter RECV, bit count 1; start bit 1 is ignored, stay IDLE, no err.
REQ-014 SHALL in RECV shift bits until bit count 11, then enter CHECK for exactly one cycle.
REQ-015 SHALL in CHECK accept byte if parity odd and stop 1; else pulse err, discard byte, clear prefix flags.
REQ-016 SHALL in RECV count cycles since last falling edge; at TIMEOUT return to IDLE, clear bit count, pulse err; prefix flags kept.
REQ-017 SHALL on accepted 0xE0 set ext flag; on 0xF0 set rel flag; flags accepted in any order; no emit.
REQ-018 SHALL on accepted 0xE1 discard that byte and the next 7 accepted bytes, then emit pressed=1, ext=1, code 0x77; no release event emitted.
REQ-019 SHALL discard 0x12 and 0x59 when ext flag set (fake shifts), clearing flags, no emit.
REQ-020 SHALL discard 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFD, 0xFE, 0xFF when no flag set, no emit.
REQ-021 SHALL on any other accepted byte emit: ps2_key[10] inverted, [9] = ~rel, [8] = ext, [7:0] = byte; then clear both flags.
REQ-022 SHALL update ps2_key on the clock edge after the CHECK cycle (2 cycles after the stop-bit sampling edge); stable between events.
REQ-023 SHALL never change ps2_key on err, on prefix bytes, or on discarded bytes.
REQ-024 SHALL never change ps2_key[10] more than once per 11 filtered-clock falling edges.
REQ-025 SHALL, if a falling edge and timeout coincide, take the edge and restart the timeout count.

Reset
REQ-026 SHALL on reset set ps2_key = 0, err = 0, FSM IDLE, bit count 0, flags clear, pause skip count 0, timeout count 0.
REQ-027 SHALL on reset set filtered clock and synchronizers to 1 (idle-high line).
REQ-028 SHALL on reset mid-frame discard the partial frame; the next complete frame after release decodes normally.
REQ-029 SHALL give reset priority over all other activity in the same cycle.

Verification
REQ-030 SHALL verify: frame 0x1C, parity 0 bit 1 after reset -> ps2_key = 0x61C (toggle 1, pressed, not ext), err never high.
REQ-031 SHALL verify: frames E0, F0, 6B -> single ps2_key change to toggle flipped, [9]=0, [8]=1, [7:0]=0x6B; unchanged after E0 and F0.
REQ-032 SHALL verify: F0 then 0x1C with bad parity -> err one cycle, ps2_key unchanged; next 0x1A -> [9]=1, [8]=0, code 0x1A (flag cleared).
REQ-033 SHALL verify: 5 bits then idle TIMEOUT cycles -> err one cycle, FSM IDLE; following 0x29 frame -> code 0x29 emitted.
REQ-034 SHALL verify: E1 14 77 E1 F0 14 F0 77 -> exactly one event, [9]=1, [8]=1, code 0x77.
REQ-035 SHALL verify: 3-cycle low glitch on ps2_clk (FILTER_LEN=8) inside a frame -> no extra bit, byte decodes correctly.
